// File: rtl/step_dir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : step_dir_pkg
//  Description : Shared types and constants for the step/direction driver.
//                - state_e       : move FSM states
//                - WIDTH_DEFAULT : default position/target width
//                - HALF          : tie threshold for shortest-path selection
//                - half_of()     : 2^(w-1) for an arbitrary width
//  Revision    : 1.0 - initial release
// ============================================================================
package step_dir_pkg;

    localparam int unsigned WIDTH_DEFAULT = 4;

    // A distance of exactly half the ring is resolved in the up direction.
    function automatic int unsigned half_of(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    localparam int unsigned HALF = half_of(WIDTH_DEFAULT);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_STEP  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage : step_dir_pkg
`default_nettype wire

// File: rtl/step_gap_timer.sv
`default_nettype none
// ============================================================================
//  Module      : step_gap_timer
//  Description : Down-counter that times the idle cycles between step pulses.
//                Loaded with STEP_GAP-1, it counts down while running and
//                flags expiry during the last gap cycle.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                i_load        - reload the counter (asserted in STEP)
//                i_run         - count down (asserted in GAP)
//                o_expired     - current cycle is the final gap cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module step_gap_timer #(
    parameter int STEP_GAP = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_run,
    output logic o_expired
);

    localparam int CW = (STEP_GAP > 2) ? $clog2(STEP_GAP) : 1;
    localparam logic [CW-1:0] C_LOAD = CW'(STEP_GAP - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    logic [CW-1:0] r_cnt_q;
    logic [CW-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (i_load) begin
            w_cnt_d = C_LOAD;
        end else if (i_run && (r_cnt_q != '0)) begin
            w_cnt_d = r_cnt_q - C_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    // The counter holds STEP_GAP-1 .. 1 across the gap cycles, so the value 1
    // marks the last one.
    assign o_expired = (r_cnt_q == C_ONE);

endmodule : step_gap_timer
`default_nettype wire

// File: rtl/step_dir_driver.sv
`default_nettype none
// ============================================================================
//  Module      : step_dir_driver
//  Description : Step/direction command generator for a modulo-2^WIDTH
//                up/down counter. Accepts a target, picks the shortest path,
//                emits spaced one-cycle step pulses with a pre-set direction
//                and tracks a shadow copy of the counter position.
//  Ports       : clk, rst                   - clock, sync active-high reset
//                target_valid/target_ready  - target handshake
//                target[WIDTH-1:0]          - requested position
//                step                       - one-cycle move pulse
//                S                          - direction (1 = up, 0 = down)
//                pos[WIDTH-1:0]             - shadow position
//                busy                       - move in progress
//                done                       - one-cycle move-complete pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module step_dir_driver
    import step_dir_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEFAULT,
    parameter int STEP_GAP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             target_valid,
    output logic             target_ready,
    input  logic [WIDTH-1:0] target,
    output logic             step,
    output logic             S,
    output logic [WIDTH-1:0] pos,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] C_HALF = WIDTH'(half_of(WIDTH));
    localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

    state_e           r_state_q, w_state_d;
    logic [WIDTH-1:0] r_pos_q,   w_pos_d;
    logic [WIDTH-1:0] r_rem_q,   w_rem_d;
    logic             r_dir_q,   w_dir_d;

    logic [WIDTH-1:0] w_delta;
    logic [WIDTH-1:0] w_rem_dec;
    logic             w_accept;
    logic             w_gap_expired;

    assign w_delta   = target - r_pos_q;
    assign w_rem_dec = r_rem_q - C_ONE;
    assign w_accept  = target_valid && (r_state_q == ST_IDLE);

    step_gap_timer #(
        .STEP_GAP (STEP_GAP)
    ) u_gap_timer (
        .clk       (clk),
        .rst       (rst),
        .i_load    (r_state_q == ST_STEP),
        .i_run     (r_state_q == ST_GAP),
        .o_expired (w_gap_expired)
    );

    // ---------------- state and datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_pos_q   <= '0;
            r_rem_q   <= '0;
            r_dir_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_pos_q   <= w_pos_d;
            r_rem_q   <= w_rem_d;
            r_dir_q   <= w_dir_d;
        end
    end

    // ---------------- next-state and datapath ----------------
    always_comb begin
        w_state_d = r_state_q;
        w_pos_d   = r_pos_q;
        w_rem_d   = r_rem_q;
        w_dir_d   = r_dir_q;
        case (r_state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_delta == '0) begin
                        w_state_d = ST_DONE;
                    end else begin
                        w_state_d = ST_SETUP;
                        // Direction is latched here so it is already stable
                        // during SETUP, a full cycle ahead of the first step.
                        if (w_delta <= C_HALF) begin
                            w_dir_d = 1'b1;
                            w_rem_d = w_delta;
                        end else begin
                            w_dir_d = 1'b0;
                            w_rem_d = '0 - w_delta;
                        end
                    end
                end
            end
            ST_SETUP: begin
                w_state_d = ST_STEP;
            end
            ST_STEP: begin
                w_pos_d   = r_dir_q ? (r_pos_q + C_ONE) : (r_pos_q - C_ONE);
                w_rem_d   = w_rem_dec;
                w_state_d = (w_rem_dec != '0) ? ST_GAP : ST_DONE;
            end
            ST_GAP: begin
                if (w_gap_expired) begin
                    w_state_d = ST_STEP;
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        step         = (r_state_q == ST_STEP);
        done         = (r_state_q == ST_DONE);
        busy         = (r_state_q != ST_IDLE);
        target_ready = (r_state_q == ST_IDLE);
        S            = r_dir_q;
        pos          = r_pos_q;
    end

endmodule : step_dir_driver
`default_nettype wire
